arbitro_scheduler: RTL and testbench



---
 rtl/arbitro_pkg.sv | 17 +
 rtl/arbitro_scheduler_if.sv | 32 +++
 rtl/arbitro_elig.sv | 15 +
 rtl/arbitro_scheduler.sv | 109 ++++++++++
 tb/tb_arbitro_scheduler.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/arbitro_pkg.sv
// Shared definitions for the two-VC routing arbiter: word geometry, scheduler
// state encoding and destination-bit extraction.
package arbitro_pkg;

    localparam int unsigned WIDTH    = 6;
    localparam int unsigned DEST_BIT = 4;

    typedef enum logic {
        StActive = 1'b0,
        StStarve = 1'b1
    } sched_state_e;

    function automatic logic dest_of(input logic [WIDTH-1:0] head);
        return head[DEST_BIT];
    endfunction

endpackage

// File: rtl/arbitro_scheduler_if.sv
// FIFO/pause/datapath signal bundle of the pop scheduler.
// The slave modport is the scheduler side; master is the FIFO/datapath side.
interface arbitro_scheduler_if
    import arbitro_pkg::*;
#(
    parameter int unsigned STALL_W = 8
);
    logic [WIDTH-1:0]   VC0_head;
    logic [WIDTH-1:0]   VC1_head;
    logic               VC0_empty;
    logic               VC1_empty;
    logic               D0_pause;
    logic               D1_pause;
    logic               VC0_pop;
    logic               VC1_pop;
    logic               pop_delay_VC0;
    logic               pop_delay_VC1;
    logic               destiny;
    logic               idle;
    logic [STALL_W-1:0] stall_cnt;

    modport master (
        output VC0_head, VC1_head, VC0_empty, VC1_empty, D0_pause, D1_pause,
        input  VC0_pop, VC1_pop, pop_delay_VC0, pop_delay_VC1, destiny, idle, stall_cnt
    );

    modport slave (
        input  VC0_head, VC1_head, VC0_empty, VC1_empty, D0_pause, D1_pause,
        output VC0_pop, VC1_pop, pop_delay_VC0, pop_delay_VC1, destiny, idle, stall_cnt
    );

endinterface

// File: rtl/arbitro_elig.sv
// Combinational eligibility of one VC: non-empty and its head's destination
// not paused.
module arbitro_elig
    import arbitro_pkg::*;
(
    input  logic [WIDTH-1:0] head_i,
    input  logic             empty_i,
    input  logic             d0_pause_i,
    input  logic             d1_pause_i,
    output logic             elig_o
);

    assign elig_o = !empty_i && !(dest_of(head_i) ? d1_pause_i : d0_pause_i);

endmodule

// File: rtl/arbitro_scheduler.sv
// Pop scheduler: VC0 strict priority with a starvation guard for VC1, skipping
// VCs whose head destination is paused.
module arbitro_scheduler
    import arbitro_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned STALL_W      = 8
) (
    input  logic                clk,
    input  logic                reset_L,
    arbitro_scheduler_if.slave  bus
);

    localparam logic [3:0]         StarveLim = 4'(STARVE_LIMIT);
    localparam logic [STALL_W-1:0] StallMax  = {STALL_W{1'b1}};

    logic elig0, elig1;
    logic vc0_pop, vc1_pop;

    sched_state_e       state_q, state_d;
    logic [3:0]         starve_q, starve_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               pd0_q, pd1_q;
    logic               destiny_q, destiny_d;
    logic               idle_q;

    arbitro_elig u_elig0 (
        .head_i     (bus.VC0_head),
        .empty_i    (bus.VC0_empty),
        .d0_pause_i (bus.D0_pause),
        .d1_pause_i (bus.D1_pause),
        .elig_o     (elig0)
    );

    arbitro_elig u_elig1 (
        .head_i     (bus.VC1_head),
        .empty_i    (bus.VC1_empty),
        .d0_pause_i (bus.D0_pause),
        .d1_pause_i (bus.D1_pause),
        .elig_o     (elig1)
    );

    always_comb begin
        vc0_pop   = 1'b0;
        vc1_pop   = 1'b0;
        starve_d  = starve_q;
        state_d   = state_q;
        stall_d   = stall_q;
        destiny_d = destiny_q;

        if (reset_L) begin
            if (state_q == StStarve) begin
                if (elig1)      vc1_pop = 1'b1;
                else if (elig0) vc0_pop = 1'b1;
            end else begin
                if (elig0)      vc0_pop = 1'b1;
                else if (elig1) vc1_pop = 1'b1;
            end
        end

        // Run length of VC0 grants taken while VC1 was waiting.
        if (vc1_pop || !elig1) begin
            starve_d = 4'd0;
        end else if (vc0_pop && starve_q != StarveLim) begin
            starve_d = starve_q + 4'd1;
        end

        unique case (state_q)
            StActive: if (starve_d == StarveLim) state_d = StStarve;
            StStarve: if (vc1_pop || !elig1)    state_d = StActive;
        endcase

        if ((!bus.VC0_empty || !bus.VC1_empty) && !elig0 && !elig1 && stall_q != StallMax) begin
            stall_d = stall_q + 1'b1;
        end

        if (vc0_pop)      destiny_d = dest_of(bus.VC0_head);
        else if (vc1_pop) destiny_d = dest_of(bus.VC1_head);
    end

    always_ff @(posedge clk) begin
        if (!reset_L) begin
            state_q   <= StActive;
            starve_q  <= 4'd0;
            stall_q   <= '0;
            pd0_q     <= 1'b0;
            pd1_q     <= 1'b0;
            destiny_q <= 1'b0;
            idle_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            starve_q  <= starve_d;
            stall_q   <= stall_d;
            pd0_q     <= vc0_pop;
            pd1_q     <= vc1_pop;
            destiny_q <= destiny_d;
            idle_q    <= !(vc0_pop || vc1_pop);
        end
    end

    assign bus.VC0_pop       = vc0_pop;
    assign bus.VC1_pop       = vc1_pop;
    assign bus.pop_delay_VC0 = pd0_q;
    assign bus.pop_delay_VC1 = pd1_q;
    assign bus.destiny       = destiny_q;
    assign bus.idle          = idle_q;
    assign bus.stall_cnt     = stall_q;

endmodule

// File: tb/tb_arbitro_scheduler.sv
// Scoreboard bench for arbitro_scheduler: directed scenarios plus random
// traffic, checked against a behavioural model of the grant rules.
module tb_arbitro_scheduler;
    import arbitro_pkg::*;

    localparam int unsigned LIMIT   = 4;
    localparam int unsigned STALL_W = 8;
    localparam int          SAT     = (1 << STALL_W) - 1;

    logic clk = 1'b0;
    logic reset_L;
    always #5 clk = ~clk;

    arbitro_scheduler_if #(.STALL_W(STALL_W)) bus ();

    arbitro_scheduler #(
        .STARVE_LIMIT (LIMIT),
        .STALL_W      (STALL_W)
    ) dut (
        .clk     (clk),
        .reset_L (reset_L),
        .bus     (bus)
    );

    typedef struct packed {
        logic               pop0;
        logic               pop1;
        logic               pd0;
        logic               pd1;
        logic               dest;
        logic               idle;
        logic [STALL_W-1:0] stall;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: VC1 gets priority once VC0 has won LIMIT times in a row over it.
    int m_run, m_stall;
    bit m_pd0, m_pd1, m_dest, m_idle;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: got %0h want %0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("VC0_pop", 32'(bus.VC0_pop), 32'(e.pop0));
            chk("VC1_pop", 32'(bus.VC1_pop), 32'(e.pop1));
            chk("pop_delay_VC0", 32'(bus.pop_delay_VC0), 32'(e.pd0));
            chk("pop_delay_VC1", 32'(bus.pop_delay_VC1), 32'(e.pd1));
            chk("destiny", 32'(bus.destiny), 32'(e.dest));
            chk("idle", 32'(bus.idle), 32'(e.idle));
            chk("stall_cnt", 32'(bus.stall_cnt), 32'(e.stall));
        end
    end

    task automatic model_reset();
        m_run = 0; m_stall = 0; m_pd0 = 0; m_pd1 = 0; m_dest = 0; m_idle = 1;
    endtask

    task automatic step(input logic rst_n, input logic [WIDTH-1:0] h0, input logic [WIDTH-1:0] h1,
                        input logic e0, input logic e1, input logic p0, input logic p1);
        bit el0, el1, g0, g1;
        exp_t e;
        reset_L       = rst_n;
        bus.VC0_head  = h0;
        bus.VC1_head  = h1;
        bus.VC0_empty = e0;
        bus.VC1_empty = e1;
        bus.D0_pause  = p0;
        bus.D1_pause  = p1;

        el0 = !e0 && !(h0[DEST_BIT] ? p1 : p0);
        el1 = !e1 && !(h1[DEST_BIT] ? p1 : p0);
        g0 = 0; g1 = 0;
        if (rst_n) begin
            if (m_run >= LIMIT) begin g1 = el1; g0 = !el1 && el0; end
            else                begin g0 = el0; g1 = !el0 && el1; end
        end
        e = '{pop0: g0, pop1: g1, pd0: m_pd0, pd1: m_pd1, dest: m_dest, idle: m_idle,
              stall: STALL_W'(m_stall)};
        exp_q.push_back(e);

        if (!rst_n) begin
            model_reset();
        end else begin
            m_pd0 = g0;
            m_pd1 = g1;
            m_idle = !(g0 || g1);
            if (g0) m_dest = h0[DEST_BIT];
            if (g1) m_dest = h1[DEST_BIT];
            if ((!e0 || !e1) && !el0 && !el1 && m_stall < SAT) m_stall++;
            if (g1 || !el1) m_run = 0;
            else if (g0 && m_run < LIMIT) m_run++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [WIDTH-1:0] a, b;
        a = 6'b000011;
        b = 6'b000101;
        reset_L = 1'b0;
        bus.VC0_head = a; bus.VC1_head = b;
        bus.VC0_empty = 1'b0; bus.VC1_empty = 1'b0;
        bus.D0_pause = 1'b0; bus.D1_pause = 1'b0;
        @(posedge clk);
        #1;
        model_reset();

        // Reset held with data present, then first release cycle.
        repeat (2) step(1'b0, a, b, 1'b0, 1'b0, 1'b0, 1'b0);
        // Starvation pattern, both heads to D0.
        repeat (20) step(1'b1, a, b, 1'b0, 1'b0, 1'b0, 1'b0);
        // VC0 head to paused D1, VC1 head to D0; then D1 released.
        repeat (6) step(1'b1, 6'b010001, 6'b000110, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (3) step(1'b1, 6'b010001, 6'b000110, 1'b0, 1'b0, 1'b0, 1'b0);
        // Full stall long enough to saturate.
        step(1'b0, a, b, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (300) step(1'b1, a, b, 1'b0, 1'b0, 1'b1, 1'b1);
        // VC1 empties while starving.
        step(1'b0, a, b, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (4) step(1'b1, a, b, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b1, a, b, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (6) step(1'b1, a, b, 1'b0, 1'b0, 1'b0, 1'b0);
        // Reset right after a VC1 pop.
        step(1'b0, a, b, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (5) step(1'b1, a, b, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, a, b, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (6) step(1'b1, a, b, 1'b0, 1'b0, 1'b0, 1'b0);
        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            step(1'($urandom_range(0, 60) != 0), WIDTH'($urandom), WIDTH'($urandom),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 4) == 0));
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
